pr_module_pt_buffered: RTL and testbench

PR_MODULE_PT_BUFFERED -- requirements
Module: pr_module_pt_buffered

---
 rtl/rca_config.sv | 19 +
 rtl/pr_pt_fifo.sv | 58 +++++
 rtl/pr_module_pt_buffered.sv | 117 +++++++++++
 tb/tb_pr_module_pt_buffered.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rca_config.sv
// Shared configuration for the pass-through buffer family: data width,
// default depth, mode selection and round-robin channel encoding.
package rca_config;

  localparam int XLEN = 32;
  localparam int PR_PT_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    PT_IN1   = 2'd0,
    PT_IN2   = 2'd1,
    PT_MERGE = 2'd2
  } pr_pt_mode_t;

  typedef enum logic {
    RR_CH1 = 1'b0,
    RR_CH2 = 1'b1
  } pr_rr_ch_t;

endpackage

// File: rtl/pr_pt_fifo.sv
// Circular FIFO: unreset storage, wrapping head/tail pointers and entry count.
// The head word is read combinationally from registered state.
module pr_pt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [OCC_W-1:0] count_reg;
  logic             pop_ok;

  // Guard against popping an empty buffer even if the caller misbehaves.
  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= (tail_reg == LAST_PTR) ? '0 : tail_reg + 1'b1;
      end
      if (pop_ok) begin
        head_reg <= (head_reg == LAST_PTR) ? '0 : head_reg + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = mem[head_reg];
  assign count = count_reg;

endmodule

// File: rtl/pr_module_pt_buffered.sv
// Buffered pass-through: forwards one input channel (or a round-robin merge of
// both) into a FIFO. Arbitration and acks live here; storage is in pr_pt_fifo.
module pr_module_pt_buffered
  import rca_config::*;
#(
  parameter int          WIDTH = XLEN,
  parameter int          DEPTH = PR_PT_DEFAULT_DEPTH,
  parameter pr_pt_mode_t MODE  = PT_IN2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in1,
  input  logic [WIDTH-1:0]           data_in2,
  input  logic                       data_valid_in1,
  input  logic                       data_valid_in2,
  output logic                       data_in_ack1,
  output logic                       data_in_ack2,
  output logic                       uses_data_in1,
  output logic                       uses_data_in2,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid_out,
  input  logic                       data_out_ack,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [WIDTH-1:0]           addr,
  output logic [WIDTH-1:0]           data,
  output logic [2:0]                 fn3,
  output logic                       load,
  output logic                       store,
  output logic                       new_request,
  input  logic                       lsq_full,
  input  logic                       load_complete,
  input  logic [WIDTH-1:0]           load_data
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  pr_rr_ch_t        rr_ptr_reg;
  logic             pop;
  logic             space;
  logic             grant1;
  logic             grant2;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             unused_lsq;

  assign uses_data_in1 = (MODE == PT_IN1) || (MODE == PT_MERGE);
  assign uses_data_in2 = (MODE == PT_IN2) || (MODE == PT_MERGE);

  assign data_valid_out = (occupancy != '0);
  assign pop   = data_valid_out && data_out_ack;
  assign space = (occupancy < FULL_COUNT) || pop;

  // Acks are held low while reset is asserted, even though the buffer is empty.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (rst && space) begin
      case (MODE)
        PT_IN1: grant1 = data_valid_in1;
        PT_IN2: grant2 = data_valid_in2;
        PT_MERGE: begin
          if (data_valid_in1 && data_valid_in2) begin
            grant1 = (rr_ptr_reg == RR_CH1);
            grant2 = (rr_ptr_reg == RR_CH2);
          end else begin
            grant1 = data_valid_in1;
            grant2 = data_valid_in2;
          end
        end
        default: begin
          grant1 = 1'b0;
          grant2 = 1'b0;
        end
      endcase
    end
  end

  // After each grant the pointer names the other channel, so contention alternates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= RR_CH1;
    end else if (grant1) begin
      rr_ptr_reg <= RR_CH2;
    end else if (grant2) begin
      rr_ptr_reg <= RR_CH1;
    end
  end

  assign data_in_ack1 = grant1;
  assign data_in_ack2 = grant2;
  assign push      = grant1 || grant2;
  assign push_data = grant1 ? data_in1 : data_in2;

  pr_pt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (data_out),
    .count (occupancy)
  );

  // This block never issues memory requests; the LSQ response side is unused.
  assign addr        = '0;
  assign data        = '0;
  assign fn3         = '0;
  assign load        = 1'b0;
  assign store       = 1'b0;
  assign new_request = 1'b0;
  assign unused_lsq  = ^{lsq_full, load_complete, load_data};

endmodule

// File: tb/tb_pr_module_pt_buffered.sv
// Scoreboard bench: instance 0 is PT_IN2, instance 1 is PT_MERGE, both DEPTH 4.
module tb_pr_module_pt_buffered;
  import rca_config::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  v1 = '0, v2 = '0, oack = '0;
  logic [31:0] d1 [2];
  logic [31:0] d2 [2];
  logic [1:0]  ack1, ack2, uses1, uses2, dvo;
  logic [31:0] dout [2];
  logic [2:0]  occ [2];
  logic [31:0] addr_o [2];
  logic [31:0] data_o [2];
  logic [2:0]  fn3_o [2];
  logic [1:0]  load_o, store_o, nreq_o;

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pr_module_pt_buffered #(.WIDTH(32), .DEPTH(4), .MODE(PT_IN2)) dut0 (
    .clk(clk), .rst(rst),
    .data_in1(d1[0]), .data_in2(d2[0]),
    .data_valid_in1(v1[0]), .data_valid_in2(v2[0]),
    .data_in_ack1(ack1[0]), .data_in_ack2(ack2[0]),
    .uses_data_in1(uses1[0]), .uses_data_in2(uses2[0]),
    .data_out(dout[0]), .data_valid_out(dvo[0]), .data_out_ack(oack[0]),
    .occupancy(occ[0]),
    .addr(addr_o[0]), .data(data_o[0]), .fn3(fn3_o[0]),
    .load(load_o[0]), .store(store_o[0]), .new_request(nreq_o[0]),
    .lsq_full(1'b0), .load_complete(1'b0), .load_data(32'd0)
  );

  pr_module_pt_buffered #(.WIDTH(32), .DEPTH(4), .MODE(PT_MERGE)) dut1 (
    .clk(clk), .rst(rst),
    .data_in1(d1[1]), .data_in2(d2[1]),
    .data_valid_in1(v1[1]), .data_valid_in2(v2[1]),
    .data_in_ack1(ack1[1]), .data_in_ack2(ack2[1]),
    .uses_data_in1(uses1[1]), .uses_data_in2(uses2[1]),
    .data_out(dout[1]), .data_valid_out(dvo[1]), .data_out_ack(oack[1]),
    .occupancy(occ[1]),
    .addr(addr_o[1]), .data(data_o[1]), .fn3(fn3_o[1]),
    .load(load_o[1]), .store(store_o[1]), .new_request(nreq_o[1]),
    .lsq_full(1'b0), .load_complete(1'b0), .load_data(32'd0)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endfunction

  // Monitors: every pop is compared against the oldest expected word.
  always @(negedge clk) begin
    if (rst && dvo[0] && oack[0]) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb0_underflow: got 0x%h, expected no output", dout[0]);
      end else begin
        check("sb0_data", dout[0], q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && dvo[1] && oack[1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb1_underflow: got 0x%h, expected no output", dout[1]);
      end else begin
        check("sb1_data", dout[1], q1.pop_front());
      end
    end
  end

  // One cycle of stimulus on instance s with hand-computed expected acks.
  task automatic step(input int s, input logic iv1, input logic iv2,
                      input logic [31:0] id1, input logic [31:0] id2,
                      input logic io, input logic ea1, input logic ea2);
    v1[s] = iv1; v2[s] = iv2; d1[s] = id1; d2[s] = id2; oack[s] = io;
    @(negedge clk);
    check($sformatf("ack1_i%0d", s), {31'd0, ack1[s]}, {31'd0, ea1});
    check($sformatf("ack2_i%0d", s), {31'd0, ack2[s]}, {31'd0, ea2});
    if (ea1) begin if (s == 0) q0.push_back(id1); else q1.push_back(id1); end
    if (ea2) begin if (s == 0) q0.push_back(id2); else q1.push_back(id2); end
    @(posedge clk); #1;
    v1[s] = 1'b0; v2[s] = 1'b0; oack[s] = 1'b0;
  endtask

  task automatic chk_occ(input int s, input int e);
    check($sformatf("occ_i%0d", s), {29'd0, occ[s]}, 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lsq_any;
    d1[0] = '0; d2[0] = '0; d1[1] = '0; d2[1] = '0;
    // Reset state: valids asserted during reset must not be acked.
    v2 = 2'b11; v1 = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_ack1_i%0d", s), {31'd0, ack1[s]}, 32'd0);
      check($sformatf("rst_ack2_i%0d", s), {31'd0, ack2[s]}, 32'd0);
      check($sformatf("rst_dvo_i%0d", s), {31'd0, dvo[s]}, 32'd0);
      chk_occ(s, 0);
    end
    check("uses_i0", {30'd0, uses1[0], uses2[0]}, 32'd1);
    check("uses_i1", {30'd0, uses1[1], uses2[1]}, 32'd3);
    v1 = '0; v2 = '0;
    rst = 1'b1;

    // Single word on in2, visible the next cycle.
    step(0, 0, 1, 32'h0, 32'h1234, 0, 0, 1);
    check("t1_dvo", {31'd0, dvo[0]}, 32'd1);
    check("t1_dout", dout[0], 32'h1234);
    chk_occ(0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk_occ(0, 0);
    // in1 is unused in PT_IN2; ack on empty buffer is ignored.
    step(0, 1, 0, 32'hDEAD, 32'h0, 1, 0, 0);
    chk_occ(0, 0);

    // Fill: 5th word is held until a pop frees a slot in the same cycle.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h0, 32'h10 + 32'(i), 0, 0, i < 4);
    chk_occ(0, 4);
    step(0, 0, 1, 32'h0, 32'h14, 1, 0, 1);
    chk_occ(0, 4);

    // Full buffer, push and pop every cycle.
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 32'h0, 32'h20 + 32'(i), 1, 0, 1);
      chk_occ(0, 4);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
      chk_occ(0, 3 - i);
    end

    // Pointer wrap with occupancy 1 push+pop pairs; LSQ outputs stay 0.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'h0, 32'h30 + 32'(i), 1, 0, 1);
      chk_occ(0, 1);
      lsq_any = (|addr_o[0]) | (|data_o[0]) | (|fn3_o[0]) | load_o[0] | store_o[0] | nreq_o[0];
      check("lsq_zero_i0", {31'd0, lsq_any}, 32'd0);
    end
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk_occ(0, 0);

    // Reset mid-cycle discards buffered words.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h0, 32'h40 + 32'(i), 0, 0, 1);
    chk_occ(0, 3);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_dvo", {31'd0, dvo[0]}, 32'd0);
    chk_occ(0, 0);
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 1, 32'h0, 32'h55, 0, 0, 1);
    check("t4_dout", dout[0], 32'h55);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk_occ(0, 0);

    // Merge: contention alternates starting with in1.
    for (int k = 0; k < 8; k++)
      step(1, 1, 1, 32'hA000_0000 + 32'((k + 1) / 2), 32'hB000_0000 + 32'(k / 2),
           1, (k % 2) == 0, (k % 2) == 1);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk_occ(1, 0);
    // Single-channel grants also move the pointer.
    step(1, 0, 1, 32'h0, 32'hC0, 1, 0, 1);
    step(1, 1, 1, 32'hC1, 32'hC2, 1, 1, 0);
    step(1, 1, 1, 32'hC3, 32'hC2, 1, 0, 1);
    step(1, 1, 0, 32'hC3, 32'h0, 1, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk_occ(1, 0);

    check("sb0_left", 32'(q0.size()), 32'd0);
    check("sb1_left", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
